multicycle_cpu_core: RTL and testbench

Parametrised multicycle successor to the single-cycle 8-bit CPU datapath: same 32-bit MIPS-style encoding, generalised data width and register count. It adds a FETCH/DECODE/EXEC/MEM/WB state machine, valid/ready handshakes to instruction and data memory (wait states allowed), hardwired-zero r0, and a HALT instruction. It sits between the board top level (displays/switches via a memory-mapped I/O decoder) and the ROM/RAM wrappers.

---
 rtl/multicycle_cpu_core_if.sv | 25 ++
 rtl/multicycle_cpu_core.sv | 150 +++++++++++++++
 tb/tb_multicycle_cpu_core.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_core_if.sv
// Instruction-fetch and data-memory handshake bundle for multicycle_cpu_core.
// master = core side, slave = ROM/RAM wrapper side.
interface multicycle_cpu_core_if #(
  parameter int DATA_W = 8
);
  logic              instr_req;
  logic [DATA_W-1:0] instr_addr;
  logic              instr_valid;
  logic [31:0]       instr_data;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  instr_valid, instr_data, mem_ready, mem_rdata
  );
  modport slave (
    input  instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output instr_valid, instr_data, mem_ready, mem_rdata
  );
endinterface

// File: rtl/multicycle_cpu_core.sv
// Multicycle MIPS-style core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with
// valid/ready handshakes to instruction and data memory, hardwired-zero r0.
module multicycle_cpu_core #(
  parameter  int DATA_W = 8,
  parameter  int NREG   = 8,
  localparam int RA_W   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_cpu_core_if.master bus,
  output logic [DATA_W-1:0]    pc,
  output logic                 halted,
  output logic [2:0]           state,
  input  logic [RA_W-1:0]      dbg_ra,
  output logic [DATA_W-1:0]    dbg_rd
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t                      st, st_nx;
  logic [NREG-1:0][DATA_W-1:0] rf;
  logic [31:0]                 ir;
  logic [DATA_W-1:0]           a_q, b_q, alu_q, mdr_q, alu_y, imm, pc_inc;
  logic [5:0]                  op, funct;
  logic [RA_W-1:0]             rs, rt, rd, wr_idx;
  logic                        is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, is_nop;
  logic                        unused_ir;

  assign op        = ir[31:26];
  assign funct     = ir[5:0];
  assign rs        = ir[21 +: RA_W];
  assign rt        = ir[16 +: RA_W];
  assign rd        = ir[11 +: RA_W];
  assign imm       = ir[DATA_W-1:0];
  assign unused_ir = ^ir;
  assign pc_inc    = pc + ONE;

  assign is_r    = (op == 6'h00) &&
                   (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
  assign is_addi = (op == 6'h08);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign is_halt = (op == 6'h3F);
  // Unknown ops and unknown R-type functs both retire as pc+1 from EXEC.
  assign is_nop  = !(is_r || is_addi || is_lw || is_sw || is_beq || is_j || is_halt);
  assign wr_idx  = (op == 6'h00) ? rd : rt;

  always_comb begin
    alu_y = a_q + imm;
    if (op == 6'h00) begin
      case (funct)
        6'h22:   alu_y = a_q - b_q;
        6'h24:   alu_y = a_q & b_q;
        6'h25:   alu_y = a_q | b_q;
        6'h2A:   alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        default: alu_y = a_q + b_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_FETCH;
    else      st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      S_FETCH:  if (bus.instr_valid) st_nx = S_DECODE;
      S_DECODE: st_nx = S_EXEC;
      S_EXEC: begin
        if (is_halt)               st_nx = S_HALT;
        else if (is_r || is_addi)  st_nx = S_WB;
        else if (is_lw || is_sw)   st_nx = S_MEM;
        else                       st_nx = S_FETCH;
      end
      S_MEM:    if (bus.mem_ready) st_nx = is_lw ? S_WB : S_FETCH;
      S_WB:     st_nx = S_FETCH;
      S_HALT:   st_nx = S_HALT;
      default:  st_nx = S_FETCH;
    endcase
  end

  // Requests gated by rst so they fall the instant reset is asserted.
  always_comb begin
    bus.instr_req = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    if (rst) begin
      bus.instr_req = (st == S_FETCH);
      bus.mem_req   = (st == S_MEM);
      bus.mem_we    = (st == S_MEM) && is_sw;
    end
  end

  assign bus.instr_addr = pc;
  assign bus.mem_addr   = alu_q;
  assign bus.mem_wdata  = b_q;
  assign halted         = (st == S_HALT);
  assign state          = st;
  assign dbg_rd         = rf[dbg_ra];

  // rf[0] is never written, so it reads 0 without a read-side mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      rf    <= '0;
    end else begin
      case (st)
        S_FETCH:  if (bus.instr_valid) ir <= bus.instr_data;
        S_DECODE: begin
          a_q <= rf[rs];
          b_q <= rf[rt];
        end
        S_EXEC: begin
          alu_q <= alu_y;
          if (is_j)                      pc <= imm;
          else if (is_beq && a_q == b_q) pc <= pc_inc + imm;
          else if (is_beq || is_nop)     pc <= pc_inc;
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_lw) mdr_q <= bus.mem_rdata;
            else       pc    <= pc_inc;
          end
        end
        S_WB: begin
          if (wr_idx != '0) rf[wr_idx] <= is_lw ? mdr_q : alu_q;
          pc <= pc_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Bench for multicycle_cpu_core: directed checks plus random programs
// compared against an instruction-level interpreter, at DATA_W=8 and 12.
module tb_multicycle_cpu_core;
  localparam logic [31:0] HALT_W = 32'hFC000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  bit   sel;

  multicycle_cpu_core_if #(.DATA_W(8))  ifa();
  multicycle_cpu_core_if #(.DATA_W(12)) ifb();

  logic [7:0]  pc_a, dbg_rd_a;
  logic [11:0] pc_b, dbg_rd_b;
  logic        halted_a, halted_b;
  logic [2:0]  state_a, state_b, dbg_ra_a;
  logic [3:0]  dbg_ra_b;

  multicycle_cpu_core #(.DATA_W(8), .NREG(8)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa), .pc(pc_a), .halted(halted_a),
    .state(state_a), .dbg_ra(dbg_ra_a), .dbg_rd(dbg_rd_a));
  multicycle_cpu_core #(.DATA_W(12), .NREG(16)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb), .pc(pc_b), .halted(halted_b),
    .state(state_b), .dbg_ra(dbg_ra_b), .dbg_rd(dbg_rd_b));

  int total = 0, bad = 0;
  logic [31:0] imem [4096];
  logic [15:0] dmem [4096];
  logic [15:0] md   [4096];
  int          mr   [32];
  int fetch_a[$], fetch_t[$], st_addr[$], st_data[$], st_len[$];
  int cyc = 0, istable_bad = 0, mstable_bad = 0, iwait = 0, mwait = 0;
  bit rand_waits = 0, force_iv = 0;

  logic        act_ireq, act_mreq, act_we, act_halted;
  logic [15:0] act_iaddr, act_maddr, act_wdata;
  assign act_ireq   = sel ? ifb.instr_req  : ifa.instr_req;
  assign act_mreq   = sel ? ifb.mem_req    : ifa.mem_req;
  assign act_we     = sel ? ifb.mem_we     : ifa.mem_we;
  assign act_halted = sel ? halted_b       : halted_a;
  assign act_iaddr  = sel ? {4'h0, ifb.instr_addr} : {8'h0, ifa.instr_addr};
  assign act_maddr  = sel ? {4'h0, ifb.mem_addr}   : {8'h0, ifa.mem_addr};
  assign act_wdata  = sel ? {4'h0, ifb.mem_wdata}  : {8'h0, ifa.mem_wdata};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: inputs change on negedge, stores commit at the completing posedge.
  initial begin
    int ic, mc, iw_cur, mw_cur;
    logic [15:0] ia0, ma0, wd0;
    logic we0, iv, rdy;
    ic = 0; mc = 0; iw_cur = 0; mw_cur = 0; iv = 0; rdy = 0;
    ia0 = '0; ma0 = '0; wd0 = '0; we0 = 0;
    ifa.instr_valid = 0; ifb.instr_valid = 0; ifa.mem_ready = 0; ifb.mem_ready = 0;
    ifa.instr_data = '0; ifb.instr_data = '0; ifa.mem_rdata = '0; ifb.mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (act_mreq && rdy && act_we) begin
        dmem[act_maddr[11:0]] = act_wdata;
        st_addr.push_back(int'(act_maddr));
        st_data.push_back(int'(act_wdata));
        st_len.push_back(mc);
      end
      @(negedge clk);
      if (act_ireq) begin
        if (ic == 0) begin
          fetch_a.push_back(int'(act_iaddr));
          fetch_t.push_back(cyc);
          ia0 = act_iaddr;
          iw_cur = rand_waits ? int'($urandom_range(0, 2)) : iwait;
        end else if (act_iaddr !== ia0) istable_bad++;
        iv = (ic >= iw_cur);
        ic++;
      end else begin
        ic = 0; iv = 0;
      end
      if (act_mreq) begin
        if (mc == 0) begin
          ma0 = act_maddr; we0 = act_we; wd0 = act_wdata;
          mw_cur = rand_waits ? int'($urandom_range(0, 2)) : mwait;
        end else if ({act_maddr, act_we, act_wdata} !== {ma0, we0, wd0}) mstable_bad++;
        rdy = (mc >= mw_cur);
        mc++;
      end else begin
        mc = 0; rdy = 0;
      end
      ifa.instr_valid = iv | force_iv;
      ifb.instr_valid = iv | force_iv;
      ifa.instr_data  = imem[act_iaddr[11:0]];
      ifb.instr_data  = imem[act_iaddr[11:0]];
      ifa.mem_ready   = rdy;
      ifb.mem_ready   = rdy;
      ifa.mem_rdata   = dmem[act_maddr[11:0]][7:0];
      ifb.mem_rdata   = dmem[act_maddr[11:0]][11:0];
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = HALT_W;
  endtask

  task automatic do_reset();
    rst_a = 0; rst_b = 0;
    fetch_a.delete(); fetch_t.delete(); st_addr.delete(); st_data.delete(); st_len.delete();
    istable_bad = 0; mstable_bad = 0;
    repeat (2) @(posedge clk);
    #2;
    if (sel) rst_b = 1; else rst_a = 1;
  endtask

  task automatic rreg(input int i, output logic [15:0] v);
    dbg_ra_a = i[2:0];
    dbg_ra_b = i[3:0];
    #1;
    v = sel ? {4'h0, dbg_rd_b} : {8'h0, dbg_rd_a};
  endtask

  task automatic run_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!act_halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, act_halted, 1);
  endtask

  function automatic int sx(input int v, input int dw);
    return (v >= (1 << (dw - 1))) ? v - (1 << dw) : v;
  endfunction

  // Instruction-level interpreter over imem/md.
  task automatic model_run(input int dw, input int nreg);
    int mask, pc, op, rs, rt, rd, fn, imm, va, vb, nxt, r;
    logic [31:0] w;
    bit wr;
    mask = (1 << dw) - 1;
    pc = 0;
    for (int k = 0; k < 32; k++) mr[k] = 0;
    for (int s = 0; s < 2000; s++) begin
      w   = imem[pc];
      op  = int'(w[31:26]);
      rs  = int'(w[25:21]) & (nreg - 1);
      rt  = int'(w[20:16]) & (nreg - 1);
      rd  = int'(w[15:11]) & (nreg - 1);
      fn  = int'(w[5:0]);
      imm = int'(w[15:0]) & mask;
      va  = mr[rs];
      vb  = mr[rt];
      nxt = (pc + 1) & mask;
      if (op == 'h3F) break;
      case (op)
        'h00: begin
          wr = 1; r = 0;
          case (fn)
            'h20: r = va + vb;
            'h22: r = va - vb;
            'h24: r = va & vb;
            'h25: r = va | vb;
            'h2A: r = (sx(va, dw) < sx(vb, dw)) ? 1 : 0;
            default: wr = 0;
          endcase
          if (wr && rd != 0) mr[rd] = r & mask;
        end
        'h08: if (rt != 0) mr[rt] = (va + imm) & mask;
        'h23: if (rt != 0) mr[rt] = int'(md[(va + imm) & mask]);
        'h2B: md[(va + imm) & mask] = 16'(vb);
        'h04: if (va == vb) nxt = (pc + 1 + imm) & mask;
        'h02: nxt = imm;
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  task automatic gen_prog(input int n);
    logic [31:0] w;
    int k;
    clear_imem();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      k = $urandom_range(0, 9);
      case (k)
        0, 1: begin
          w[31:26] = 6'h00;
          case ($urandom_range(0, 5))
            0: w[5:0] = 6'h20;
            1: w[5:0] = 6'h22;
            2: w[5:0] = 6'h24;
            3: w[5:0] = 6'h25;
            4: w[5:0] = 6'h2A;
            default: w[5:0] = 6'h07;
          endcase
        end
        2, 9: w[31:26] = 6'h08;
        3:    w[31:26] = 6'h23;
        4:    w[31:26] = 6'h2B;
        5: begin
          w[31:26] = 6'h04;
          w[15:0]  = 16'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) w[20:16] = w[25:21];
        end
        6: begin
          w[31:26] = 6'h02;
          w[15:0]  = 16'(i + 1 + int'($urandom_range(0, 3)));
        end
        default: w[31:26] = 6'h11;
      endcase
      imem[i] = w;
    end
  endtask

  initial begin
    logic [15:0] v;
    int n, nbad, dw, nreg;
    sel = 0; dbg_ra_a = '0; dbg_ra_b = '0;
    clear_imem();
    for (int i = 0; i < 4096; i++) dmem[i] = '0;
    #1 rst_a = 0; rst_b = 0;

    // Reset holds requests low even with instr_valid high.
    force_iv = 1;
    repeat (3) @(negedge clk);
    chk("rst_ireq", ifa.instr_req, 0);
    chk("rst_mreq", ifa.mem_req, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_state", state_a, 0);
    chk("rst_halted", halted_a, 0);
    force_iv = 0;

    imem[0]  = 32'h20010005; imem[1]  = 32'h20020003;
    imem[2]  = 32'h00221822; imem[3]  = 32'h0041202A;
    imem[4]  = 32'h10210002; imem[7]  = 32'h10220005;
    imem[8]  = 32'h200500FF; imem[9]  = 32'h20A50001;
    imem[10] = 32'h20000007; imem[11] = 32'hAC010010;
    imem[12] = 32'h8C060010; imem[13] = 32'h08000020;
    mwait = 3;
    do_reset();
    #1;
    chk("rel_ireq", ifa.instr_req, 1);
    chk("rel_iaddr", ifa.instr_addr, 0);
    for (int r = 0; r < 8; r++) begin
      rreg(r, v);
      chk($sformatf("rst_r%0d", r), v, 0);
    end
    run_halt("p1", 300);
    chk("p1_addi_cyc", fetch_t[1] - fetch_t[0], 4);
    chk("p1_sub_cyc", fetch_t[3] - fetch_t[2], 4);
    chk("p1_beq_taken", fetch_a[5], 7);
    chk("p1_beq_cyc", fetch_t[5] - fetch_t[4], 3);
    chk("p1_beq_not", fetch_a[6], 8);
    chk("p1_sw_cyc", fetch_t[10] - fetch_t[9], 7);
    chk("p1_lw_cyc", fetch_t[11] - fetch_t[10], 8);
    chk("p1_j", fetch_a[12], 32'h20);
    chk("p1_st_addr", st_addr[0], 32'h10);
    chk("p1_st_data", st_data[0], 5);
    chk("p1_st_len", st_len[0], 4);
    chk("p1_st_stable", mstable_bad, 0);
    chk("p1_state", state_a, 5);
    rreg(0, v); chk("p1_r0", v, 0);
    rreg(3, v); chk("p1_r3", v, 2);
    rreg(4, v); chk("p1_r4", v, 1);
    rreg(5, v); chk("p1_r5", v, 0);
    rreg(6, v); chk("p1_r6", v, 5);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.instr_req || ifa.mem_req) n++;
    end
    chk("halt_noreq", n, 0);

    // pc wraps from 0xFF to 0x00.
    clear_imem();
    imem[0] = 32'h080000FF; imem[255] = 32'h0C000000;
    mwait = 0;
    do_reset();
    n = 0;
    while (fetch_a.size() < 3 && n < 50) begin @(negedge clk); n++; end
    chk("wrap_ff", fetch_a[1], 32'hFF);
    chk("wrap_00", fetch_a[2], 0);
    chk("wrap_cyc", fetch_t[2] - fetch_t[1], 3);

    // Fetch wait states, then reset during a stalled store.
    clear_imem();
    imem[0] = 32'h20010005; imem[1] = 32'hAC010010;
    dmem[16] = 16'h00AA;
    iwait = 5; mwait = 10;
    do_reset();
    n = 0;
    while (!ifa.mem_req && n < 100) begin @(negedge clk); n++; end
    chk("hs_mreq", ifa.mem_req, 1);
    chk("hs_ifetch_cyc", fetch_t[1] - fetch_t[0], 9);
    chk("hs_istable", istable_bad, 0);
    repeat (2) @(negedge clk);
    #2 rst_a = 0;
    #1;
    chk("hs_mreq_drop", ifa.mem_req, 0);
    chk("hs_mwe_drop", ifa.mem_we, 0);
    chk("hs_pc", pc_a, 0);
    @(posedge clk);
    #1;
    chk("hs_mem_kept", dmem[16], 16'h00AA);
    chk("hs_no_store", st_addr.size(), 0);

    // Wider datapath with r15.
    sel = 1; iwait = 0; mwait = 0;
    clear_imem();
    imem[0] = 32'h200F0005; imem[1] = 32'h20020003;
    imem[2] = 32'h01E21822; imem[3] = 32'h004F202A;
    imem[4] = 32'h20050FFF; imem[5] = 32'h20A50001;
    do_reset();
    run_halt("p2", 300);
    rreg(15, v); chk("p2_r15", v, 5);
    rreg(3, v);  chk("p2_r3", v, 2);
    rreg(4, v);  chk("p2_r4", v, 1);
    rreg(5, v);  chk("p2_r5", v, 0);

    // Random programs against the interpreter.
    rand_waits = 1;
    for (int d = 0; d < 2; d++) begin
      sel  = (d == 1);
      dw   = (d == 1) ? 12 : 8;
      nreg = (d == 1) ? 16 : 8;
      for (int p = 0; p < 3; p++) begin
        gen_prog(30);
        for (int i = 0; i < 4096; i++) begin
          dmem[i] = 16'($urandom & ((1 << dw) - 1));
          md[i]   = dmem[i];
        end
        do_reset();
        run_halt($sformatf("rnd%0d_%0d", d, p), 1500);
        model_run(dw, nreg);
        for (int r = 0; r < nreg; r++) begin
          rreg(r, v);
          chk($sformatf("rnd%0d_%0d_r%0d", d, p, r), v, 16'(mr[r]));
        end
        nbad = 0;
        for (int i = 0; i < 4096; i++) if (dmem[i] !== md[i]) nbad++;
        chk($sformatf("rnd%0d_%0d_dmem", d, p), nbad, 0);
        chk($sformatf("rnd%0d_%0d_mstable", d, p), mstable_bad, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
